// File: rtl/gardner_symbol_sync_if.sv
// gardner_symbol_sync_if: I/Q sample stream in, symbol stream and loop telemetry out
interface gardner_symbol_sync_if #(parameter int WIDTH = 16);
  logic signed [WIDTH-1:0] I_in, Q_in, sym_I, sym_Q;
  logic in_vld, sym_vld;
  logic signed [31:0] ted_err, loop_out;
  modport master (output I_in, Q_in, in_vld, input sym_I, sym_Q, sym_vld, ted_err, loop_out);
  modport slave (input I_in, Q_in, in_vld, output sym_I, sym_Q, sym_vld, ted_err, loop_out);
endinterface

// File: rtl/gardner_symbol_sync.sv
// gardner_symbol_sync: NCO-strobed decimation to one sample per symbol with Gardner TED and PI loop
module gardner_symbol_sync #(
  parameter int WIDTH = 16,
  parameter logic [31:0] NOM_STEP = 32'h4000_0000,
  parameter int TED_SHIFT = 8,
  parameter int KP_SHIFT = 8,
  parameter int KI_SHIFT = 12,
  parameter logic [31:0] LOOP_LIM = 32'd65536
) (
  input logic clk_32M768,
  input logic rst_n,
  gardner_symbol_sync_if.slave s
);
  localparam int DW = WIDTH + 1;
  localparam int PW = 2 * WIDTH + 1;
  localparam int SW = 2 * WIDTH + 2;
  localparam logic signed [63:0] LIM = $signed({32'd0, LOOP_LIM});
  logic [31:0] phase, step;
  logic [32:0] nxt;
  logic half, primed, strobe, v1, v2, v3;
  logic signed [WIDTH-1:0] p_i, p_q, m_i, m_q, c_i, c_q;
  logic signed [DW-1:0] d_i, d_q;
  logic signed [PW-1:0] pr_i, pr_q;
  logic signed [SW-1:0] sum;
  logic signed [63:0] e_w;
  logic signed [31:0] e, integ, integ_n, loop_n;
  function automatic logic signed [31:0] clamp(input logic signed [63:0] x);
    return x > LIM ? LIM[31:0] : x < -LIM ? 32'(-LIM) : x[31:0];
  endfunction
  always_comb begin
    step = NOM_STEP + s.loop_out;
    nxt = {1'b0, phase} + {1'b0, step};
    strobe = s.in_vld & nxt[32];
    sum = SW'(pr_i) + SW'(pr_q);
    e_w = 64'(sum >>> TED_SHIFT);
    e = e_w > 64'sh7FFF_FFFF ? 32'sh7FFF_FFFF : e_w < -64'sh8000_0000 ? 32'sh8000_0000 : e_w[31:0];
    integ_n = clamp(64'(integ) + 64'(e >>> KI_SHIFT));
    loop_n = clamp(64'(e >>> KP_SHIFT) + 64'(integ_n));
  end
  // half=0 marks the mid-symbol strobe; the TED launches only once a previous on-time sample exists
  always_ff @(posedge clk_32M768 or negedge rst_n)
    if (!rst_n) begin
      phase <= '0;
      half <= 1'b0;
      primed <= 1'b0;
      {v1, v2, v3} <= '0;
      {p_i, p_q, m_i, m_q, c_i, c_q} <= '0;
      {d_i, d_q, pr_i, pr_q} <= '0;
      integ <= '0;
      s.sym_I <= '0;
      s.sym_Q <= '0;
      s.sym_vld <= 1'b0;
      s.ted_err <= '0;
      s.loop_out <= '0;
    end else begin
      if (s.in_vld) phase <= nxt[31:0];
      if (strobe) half <= ~half;
      if (strobe & ~half) {m_i, m_q} <= {s.I_in, s.Q_in};
      if (strobe & half) begin
        {p_i, p_q, c_i, c_q} <= {c_i, c_q, s.I_in, s.Q_in};
        s.sym_I <= s.I_in;
        s.sym_Q <= s.Q_in;
        primed <= 1'b1;
      end
      s.sym_vld <= strobe & half;
      v1 <= strobe & half & primed;
      v2 <= v1;
      v3 <= v2;
      if (v1) begin
        d_i <= DW'(p_i) - DW'(c_i);
        d_q <= DW'(p_q) - DW'(c_q);
      end
      if (v2) begin
        pr_i <= PW'(m_i) * PW'(d_i);
        pr_q <= PW'(m_q) * PW'(d_q);
      end
      if (v3) begin
        s.ted_err <= e;
        integ <= integ_n;
        s.loop_out <= loop_n;
      end
    end
endmodule

// File: tb/tb_gardner_symbol_sync.sv
// tb_gardner_symbol_sync: directed vectors with hand-computed expectations for the Gardner timing loop
module tb_gardner_symbol_sync;
  localparam int WIDTH = 16;
  localparam int A = 32767;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int passed = 0, total = 0, vn = 0, cyc = 0;
  int pv[$], pc[$];
  int smp, jj, cc, mi, ml;
  gardner_symbol_sync_if #(.WIDTH(WIDTH)) bus();
  gardner_symbol_sync #(.WIDTH(WIDTH)) dut (.clk_32M768(clk), .rst_n(rst_n), .s(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic drive(input logic v, input int i, input int q);
    bus.in_vld = v;
    bus.I_in = WIDTH'(i);
    bus.Q_in = WIDTH'(q);
    if (v) vn++;
    cyc++;
    @(posedge clk);
    #1;
    if (bus.sym_vld) begin
      pv.push_back(vn);
      pc.push_back(cyc);
    end
  endtask
  task automatic clear_log();
    vn = 0;
    cyc = 0;
    pv.delete();
    pc.delete();
  endtask
  task automatic do_reset();
    bus.in_vld = 1'b0;
    bus.I_in = '0;
    bus.Q_in = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_log();
  endtask
  initial begin
    do_reset();
    chk("rst_sym_vld", bus.sym_vld, 0);
    chk("rst_sym_I", bus.sym_I, 0);
    chk("rst_sym_Q", bus.sym_Q, 0);
    chk("rst_ted_err", bus.ted_err, 0);
    chk("rst_loop_out", bus.loop_out, 0);
    // constant input: symbols at valid 8, 16, 24
    for (int n = 1; n <= 24; n++) drive(1'b1, 1000, 0);
    chk("t1_pulses", pv.size(), 3);
    chk("t1_p0", pv[0], 8);
    chk("t1_p1", pv[1], 16);
    chk("t1_p2", pv[2], 24);
    chk("t1_sym_I", bus.sym_I, 1000);
    chk("t1_ted", bus.ted_err, 0);
    chk("t1_loop", bus.loop_out, 0);
    // alternating on-time, zero mid: zero error
    do_reset();
    for (int n = 1; n <= 32; n++) begin
      smp = (n % 8 == 0) ? (((n / 8) % 2 == 1) ? 8000 : -8000) : 0;
      drive(1'b1, smp, 0);
      if (n == 24) chk("t2_sym_I_pos", bus.sym_I, 8000);
    end
    chk("t2_sym_I_neg", bus.sym_I, -8000);
    chk("t2_pulses", pv.size(), 4);
    chk("t2_ted", bus.ted_err, 0);
    chk("t2_loop", bus.loop_out, 0);
    // single I-path error then zero error: integrator keeps 15
    do_reset();
    for (int n = 1; n <= 27; n++) begin
      smp = n == 8 ? 8000 : n == 12 ? 1000 : n == 16 ? -8000 : 0;
      drive(1'b1, smp, 0);
      if (n == 18) chk("t3_ted_early", bus.ted_err, 0);
      if (n == 19) begin
        chk("t3_ted", bus.ted_err, 62500);
        chk("t3_loop", bus.loop_out, 259);
      end
    end
    chk("t3_ted_zero", bus.ted_err, 0);
    chk("t3_loop_integ", bus.loop_out, 15);
    chk("t3_p2", pv[2], 24);
    // same error on the Q path
    do_reset();
    for (int n = 1; n <= 19; n++) begin
      smp = n == 8 ? 8000 : n == 12 ? 1000 : n == 16 ? -8000 : 0;
      drive(1'b1, 0, smp);
      if (n == 16) chk("t7_sym_Q", bus.sym_Q, -8000);
    end
    chk("t7_ted", bus.ted_err, 62500);
    chk("t7_loop", bus.loop_out, 259);
    // 1-of-3 valid duty: gaps are transparent
    do_reset();
    for (int n = 1; n <= 24; n++) begin
      drive(1'b0, 7777, 7777);
      drive(1'b0, 7777, 7777);
      drive(1'b1, 1000, 0);
    end
    chk("t4_pulses", pv.size(), 3);
    chk("t4_p0", pv[0], 8);
    chk("t4_p2", pv[2], 24);
    chk("t4_gap01", pc[1] - pc[0], 24);
    chk("t4_gap12", pc[2] - pc[1], 24);
    chk("t4_sym_I", bus.sym_I, 1000);
    // maximal positive error until both clamps engage, then one negative error
    do_reset();
    mi = 0;
    for (int n = 1; n <= 331; n++) begin
      smp = 0;
      if (n % 8 == 0) begin
        jj = n / 8;
        smp = (jj % 2 == 1) ? -A : A;
      end else if (n % 8 == 4) begin
        jj = (n + 4) / 8;
        cc = (jj % 2 == 1) ? -A : A;
        smp = (jj == 41) ? cc : -cc;
      end
      drive(1'b1, smp, 0);
      if (n % 8 == 3 && n >= 19) begin
        jj = (n - 3) / 8;
        if (jj <= 40) begin
          mi = (mi + 2047 > 65536) ? 65536 : mi + 2047;
          ml = (32766 + mi > 65536) ? 65536 : 32766 + mi;
          chk($sformatf("t5_ted_%0d", jj), bus.ted_err, 8388096);
          chk($sformatf("t5_loop_%0d", jj), bus.loop_out, ml);
        end else begin
          chk("t5_ted_neg", bus.ted_err, -8388097);
          chk("t5_loop_neg", bus.loop_out, 30721);
        end
      end
    end
    chk("t5_p_last", pv[pv.size() - 1], 328);
    // asynchronous reset mid-symbol after lock
    drive(1'b1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_sym_vld", bus.sym_vld, 0);
    chk("t6_sym_I", bus.sym_I, 0);
    chk("t6_ted", bus.ted_err, 0);
    chk("t6_loop", bus.loop_out, 0);
    bus.in_vld = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_log();
    for (int n = 1; n <= 16; n++) drive(1'b1, 1000, -300);
    chk("t6_pulses", pv.size(), 2);
    chk("t6_p0", pv[0], 8);
    chk("t6_sym_I_after", bus.sym_I, 1000);
    chk("t6_sym_Q_after", bus.sym_Q, -300);
    chk("t6_ted_after", bus.ted_err, 0);
    chk("t6_loop_after", bus.loop_out, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
